// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master bus arbiter.
// Holds the active-low enable / read-write encodings, the default bus
// geometry, the arbiter state encoding and a small pointer helper.
package bus_arbiter_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int DEF_BUS_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam logic [DEF_BUS_ADDR_WIDTH-1:0] DEF_IO_BASE = 10'h200;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_t;

  // Round-robin pointer advance (wraps mod 4).
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the four masters and the arbiter / memory-IO side.
//   breq_[3:0]            per-master request, active low (0=CPU0,1=CPU1,2=DMA,3=spare)
//   bgrt_[3:0]            per-master grant, active low, one-hot-low or all high
//   addrN, wdataN, rwN_   per-master address, write data, read(1)/write(0)
//   maddr, mwdata, mrw_   owner's cycle muxed toward memory/IO
//   mem_cs_, io_cs_       address-decoded selects, active low
//   tout                  one-cycle pulse after a forced release
// Modports: master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
  parameter int BUS_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 8
);
  logic [3:0]                breq_;
  logic [3:0]                bgrt_;
  logic [BUS_ADDR_WIDTH-1:0] addr0, addr1, addr2, addr3;
  logic [DATA_WIDTH-1:0]     wdata0, wdata1, wdata2, wdata3;
  logic                      rw0_, rw1_, rw2_, rw3_;
  logic [BUS_ADDR_WIDTH-1:0] maddr;
  logic [DATA_WIDTH-1:0]     mwdata;
  logic                      mrw_;
  logic                      mem_cs_;
  logic                      io_cs_;
  logic                      tout;

  modport master (
    output breq_, addr0, addr1, addr2, addr3,
           wdata0, wdata1, wdata2, wdata3, rw0_, rw1_, rw2_, rw3_,
    input  bgrt_, maddr, mwdata, mrw_, mem_cs_, io_cs_, tout
  );

  modport slave (
    input  breq_, addr0, addr1, addr2, addr3,
           wdata0, wdata1, wdata2, wdata3, rw0_, rw1_, rw2_, rw3_,
    output bgrt_, maddr, mwdata, mrw_, mem_cs_, io_cs_, tout
  );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req[3:0]    active-high requests
//   ptr[1:0]    scan start position
//   winner[1:0] first requester at or above ptr (mod 4)
//   valid       any request present
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);
  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest hit wins last.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with tenure-limited preemption.
// Ports:
//   clk     rising-edge clock
//   reset_  asynchronous active-low reset
//   bus     bus_arbiter_if.slave (requests, master cycles, muxed cycle, selects, tout)
//
// state | meaning
// IDLE  | no owner, grant the round-robin winner at the next edge
// GRANT | owner holds the bus, its cycle is muxed out and decoded
// TURN  | one all-high gap cycle after any release, then regrant or idle
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int                        BUS_ADDR_WIDTH = DEF_BUS_ADDR_WIDTH,
  parameter int                        DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter logic [BUS_ADDR_WIDTH-1:0] IO_BASE        = BUS_ADDR_WIDTH'(DEF_IO_BASE),
  parameter logic [7:0]                MAX_TENURE     = 8'd64
) (
  input logic          clk,
  input logic          reset_,
  bus_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] tenure_q, tenure_d;
  logic       tout_q, tout_d;

  logic [3:0] req;
  logic [3:0] owner_mask;
  logic [1:0] pick;
  logic       pick_vld;
  logic       owner_req;
  logic       other_req;
  logic       tenure_hit;

  logic [3:0]                bgrt;
  logic [BUS_ADDR_WIDTH-1:0] maddr;
  logic [DATA_WIDTH-1:0]     mwdata;
  logic                      mrw;
  logic                      mem_cs;
  logic                      io_cs;

  assign req        = ~bus.breq_;
  assign owner_mask = 4'b0001 << owner_q;
  assign owner_req  = req[owner_q];
  assign other_req  = |(req & ~owner_mask);
  assign tenure_hit = (MAX_TENURE != 8'd0) && (tenure_q == MAX_TENURE - 8'd1);

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (rr_q),
    .winner (pick),
    .valid  (pick_vld)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      rr_q     <= 2'd0;
      tenure_q <= 8'd0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      tenure_q <= tenure_d;
      tout_q   <= tout_d;
    end
  end

  // rr always points one past the latest owner, so a preempted master is
  // naturally skipped on the regrant out of TURN.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    tenure_d = tenure_q;
    tout_d   = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (pick_vld) begin
          state_d  = GRANT;
          owner_d  = pick;
          rr_d     = next_ptr(pick);
          tenure_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (tenure_q != 8'hFF) tenure_d = tenure_q + 8'd1;
        if (!owner_req) begin
          state_d = TURN;
        end else if (tenure_hit && other_req) begin
          state_d = TURN;
          tout_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bgrt   = 4'hF;
    maddr  = '0;
    mwdata = '0;
    mrw    = READ;
    mem_cs = DISABLE_;
    io_cs  = DISABLE_;
    if (state_q == GRANT) begin
      bgrt[owner_q] = ENABLE_;
      case (owner_q)
        2'd0:    begin maddr = bus.addr0; mwdata = bus.wdata0; mrw = bus.rw0_; end
        2'd1:    begin maddr = bus.addr1; mwdata = bus.wdata1; mrw = bus.rw1_; end
        2'd2:    begin maddr = bus.addr2; mwdata = bus.wdata2; mrw = bus.rw2_; end
        default: begin maddr = bus.addr3; mwdata = bus.wdata3; mrw = bus.rw3_; end
      endcase
      if (maddr < IO_BASE) mem_cs = ENABLE_;
      else                 io_cs  = ENABLE_;
    end
  end

  assign bus.bgrt_   = bgrt;
  assign bus.maddr   = maddr;
  assign bus.mwdata  = mwdata;
  assign bus.mrw_    = mrw;
  assign bus.mem_cs_ = mem_cs;
  assign bus.io_cs_  = io_cs;
  assign bus.tout    = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam logic [7:0] MAXT = 8'd4;
  localparam logic [9:0] IOB  = 10'h200;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  bus_arbiter_if #(.BUS_ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();

  bus_arbiter #(
    .BUS_ADDR_WIDTH (10),
    .DATA_WIDTH     (8),
    .IO_BASE        (IOB),
    .MAX_TENURE     (MAXT)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, how many grant cycles it has
  // completed, the round-robin start, and whether a preemption just happened.
  int m_owner;
  int m_rr;
  int m_held;
  bit m_tout;

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_held  = 0;
    m_tout  = 0;
  endtask

  task automatic model_edge(input logic [3:0] breq_n);
    logic [3:0] r;
    bit others;
    r = ~breq_n;
    m_tout = 0;
    if (m_owner >= 0) begin
      others = 0;
      for (int k = 0; k < 4; k++) if (k != m_owner && r[k]) others = 1;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (MAXT != 0 && m_held == int'(MAXT) - 1 && others) begin
        m_owner = -1;
        m_tout  = 1;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r[(m_rr + k) % 4]) begin
          m_owner = (m_rr + k) % 4;
          m_rr    = (m_owner + 1) % 4;
          m_held  = 0;
          break;
        end
      end
    end
  endtask

  function automatic logic [25:0] exp_out();
    logic [3:0] g;
    logic [9:0] a;
    logic [7:0] d;
    logic rw, mc, ic;
    g = 4'hF; a = '0; d = '0; rw = 1'b1; mc = 1'b1; ic = 1'b1;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b0;
      case (m_owner)
        0: begin a = bus.addr0; d = bus.wdata0; rw = bus.rw0_; end
        1: begin a = bus.addr1; d = bus.wdata1; rw = bus.rw1_; end
        2: begin a = bus.addr2; d = bus.wdata2; rw = bus.rw2_; end
        default: begin a = bus.addr3; d = bus.wdata3; rw = bus.rw3_; end
      endcase
      if (a < IOB) mc = 1'b0;
      else         ic = 1'b0;
    end
    return {g, a, d, rw, mc, ic, m_tout};
  endfunction

  function automatic logic [25:0] dut_out();
    return {bus.bgrt_, bus.maddr, bus.mwdata, bus.mrw_, bus.mem_cs_, bus.io_cs_, bus.tout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(bus.breq_);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_ = 1'b0;
    bus.breq_ = 4'hF;
    model_reset();
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return IOB - 10'd2 + 10'($urandom_range(0, 3));
    return 10'($urandom_range(0, 1023));
  endfunction

  task automatic test_reset();
    logic [25:0] idle_v;
    idle_v = {4'hF, 10'h0, 8'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    reset_ = 1'b0;
    bus.breq_ = 4'b0000;
    bus.addr0 = 10'h010; bus.addr1 = 10'h220; bus.addr2 = 10'h030; bus.addr3 = 10'h240;
    bus.wdata0 = 8'h11; bus.wdata1 = 8'h22; bus.wdata2 = 8'h33; bus.wdata3 = 8'h44;
    bus.rw0_ = WRITE; bus.rw1_ = WRITE; bus.rw2_ = WRITE; bus.rw3_ = WRITE;
    model_reset();
    #3;
    total++;
    if (dut_out() !== idle_v) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", dut_out(), idle_v);
    end
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (dut_out() !== idle_v) begin
      bad++; $display("FAIL reset_hold: got %h want %h", dut_out(), idle_v);
    end
    @(negedge clk);
    bus.breq_ = 4'hF;
    reset_ = 1'b1;
  endtask

  task automatic test_single_grant();
    bit held_ok;
    apply_reset();
    bus.breq_ = 4'b1110; bus.rw0_ = WRITE; bus.addr0 = 10'h150; bus.wdata0 = 8'h99;
    total++;
    if (bus.bgrt_ !== 4'hF) begin
      bad++; $display("FAIL grant_latency: got %b want 1111", bus.bgrt_);
    end
    tick();
    total++;
    if (bus.bgrt_ !== 4'b1110) begin bad++; $display("FAIL s1_bgrt: got %b want 1110", bus.bgrt_); end
    total++;
    if (bus.maddr !== 10'h150) begin bad++; $display("FAIL s1_maddr: got %h want 150", bus.maddr); end
    total++;
    if (bus.mwdata !== 8'h99) begin bad++; $display("FAIL s1_mwdata: got %h want 99", bus.mwdata); end
    total++;
    if (bus.mrw_ !== WRITE) begin bad++; $display("FAIL s1_mrw: got %b want 0", bus.mrw_); end
    total++;
    if ({bus.mem_cs_, bus.io_cs_} !== 2'b01) begin
      bad++; $display("FAIL s1_selects: got %b want 01", {bus.mem_cs_, bus.io_cs_});
    end
    held_ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.bgrt_ !== 4'b1110 || bus.tout !== 1'b0) held_ok = 0;
    end
    total++;
    if (!held_ok) begin bad++; $display("FAIL uncontested_hold: got 0 want 1"); end
    bus.breq_ = 4'hF;
    tick();
    total++;
    if ({bus.bgrt_, bus.tout} !== 5'b11110) begin
      bad++; $display("FAIL release_turn: got %b want 11110", {bus.bgrt_, bus.tout});
    end
    tick();
    total++;
    if ({bus.bgrt_, bus.mem_cs_, bus.io_cs_, bus.maddr} !== {4'hF, 2'b11, 10'h0}) begin
      bad++; $display("FAIL idle_outputs: got %h want %h",
                      {bus.bgrt_, bus.mem_cs_, bus.io_cs_, bus.maddr}, {4'hF, 2'b11, 10'h0});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [14];
    logic       exp_t [14];
    for (int i = 0; i < 14; i++) begin
      exp_g[i] = (i < 4 || i >= 10) ? 4'b1110 : (i == 4 || i == 9) ? 4'hF : 4'b1011;
      exp_t[i] = (i == 4 || i == 9);
    end
    apply_reset();
    bus.breq_ = 4'b1010;
    for (int i = 0; i < 14; i++) begin
      tick();
      total++;
      if (bus.bgrt_ !== exp_g[i]) begin
        bad++; $display("FAIL rr_bgrt[%0d]: got %b want %b", i, bus.bgrt_, exp_g[i]);
      end
      total++;
      if (bus.tout !== exp_t[i]) begin
        bad++; $display("FAIL rr_tout[%0d]: got %b want %b", i, bus.tout, exp_t[i]);
      end
    end
  endtask

  task automatic test_io_decode();
    logic [9:0] a_tab [5];
    logic [1:0] s_tab [5];
    a_tab[0] = 10'h204; s_tab[0] = 2'b10;
    a_tab[1] = 10'h1FF; s_tab[1] = 2'b01;
    a_tab[2] = 10'h200; s_tab[2] = 2'b10;
    a_tab[3] = 10'h000; s_tab[3] = 2'b01;
    a_tab[4] = 10'h3FF; s_tab[4] = 2'b10;
    apply_reset();
    bus.addr2 = a_tab[0]; bus.rw2_ = READ; bus.wdata2 = 8'h5A;
    bus.breq_ = 4'b1011;
    tick();
    total++;
    if (bus.bgrt_ !== 4'b1011) begin bad++; $display("FAIL dma_grant: got %b want 1011", bus.bgrt_); end
    for (int i = 0; i < 5; i++) begin
      bus.addr2 = a_tab[i];
      #1;
      total++;
      if (bus.maddr !== a_tab[i]) begin
        bad++; $display("FAIL decode_maddr[%0d]: got %h want %h", i, bus.maddr, a_tab[i]);
      end
      total++;
      if ({bus.mem_cs_, bus.io_cs_} !== s_tab[i]) begin
        bad++; $display("FAIL decode_sel[%0d]: got %b want %b", i, {bus.mem_cs_, bus.io_cs_}, s_tab[i]);
      end
    end
  endtask

  task automatic test_tenure();
    int grant0, touts, cpu1_at;
    grant0 = 0; touts = 0; cpu1_at = -1;
    apply_reset();
    bus.breq_ = 4'b1110;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (n == 0) bus.breq_ = 4'b1100;
      if (bus.bgrt_ === 4'b1110) grant0++;
      if (bus.tout === 1'b1) touts++;
      if (bus.bgrt_ === 4'b1101) begin
        cpu1_at = n;
        break;
      end
    end
    total++;
    if (grant0 != 4) begin bad++; $display("FAIL tenure_cycles: got %0d want 4", grant0); end
    total++;
    if (touts != 1) begin bad++; $display("FAIL tenure_tout: got %0d want 1", touts); end
    total++;
    if (cpu1_at != 5) begin bad++; $display("FAIL tenure_next_grant: got %0d want 5", cpu1_at); end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    bus.addr2 = 10'h204;
    bus.breq_ = 4'b1011;
    tick();
    total++;
    if (bus.bgrt_ !== 4'b1011) begin bad++; $display("FAIL s5_grant: got %b want 1011", bus.bgrt_); end
    #2;
    reset_ = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus.bgrt_ !== 4'hF) begin bad++; $display("FAIL s5_async_bgrt: got %b want 1111", bus.bgrt_); end
    total++;
    if ({bus.mem_cs_, bus.io_cs_, bus.tout} !== 3'b110) begin
      bad++; $display("FAIL s5_async_sel: got %b want 110", {bus.mem_cs_, bus.io_cs_, bus.tout});
    end
    bus.breq_ = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    tick();
    total++;
    if (bus.bgrt_ !== 4'b1101) begin bad++; $display("FAIL s5_regrant: got %b want 1101", bus.bgrt_); end
  endtask

  task automatic test_random();
    logic [25:0] want, got;
    logic [3:0]  flip;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      bus.breq_ = bus.breq_ ^ flip;
      bus.addr0 = rand_addr(); bus.addr1 = rand_addr();
      bus.addr2 = rand_addr(); bus.addr3 = rand_addr();
      bus.wdata0 = 8'($urandom); bus.wdata1 = 8'($urandom);
      bus.wdata2 = 8'($urandom); bus.wdata3 = 8'($urandom);
      bus.rw0_ = 1'($urandom); bus.rw1_ = 1'($urandom);
      bus.rw2_ = 1'($urandom); bus.rw3_ = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset_ = 1'b0;
        model_reset();
        #1;
        reset_ = 1'b1;
      end
      tick();
      want = exp_out();
      got  = dut_out();
      total++;
      if (got !== want) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", n, got, want);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_io_decode();
    test_tenure();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter BUS_ADDR_WIDTH, default 10: the bus address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8: the bus data width.
REQ-003 The module SHALL have parameter IO_BASE, default 10'h200: the lowest IO address; addresses below it map to memory.
REQ-004 The module SHALL have parameter MAX_TENURE, default 8'd64: the grant-cycle limit before forced release; 0 disables the limit.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port breq_, input, 4 bits: per-master bus request, active low; 0=CPU0, 1=CPU1, 2=DMA, 3=spare.
REQ-008 The module SHALL have port bgrt_, output, 4 bits: per-master bus grant, active low, one-hot-low or all high.
REQ-009 The module SHALL have ports addr0..addr3, input, BUS_ADDR_WIDTH each: the master addresses.
REQ-010 The module SHALL have ports wdata0..wdata3, input, DATA_WIDTH each: the master write data.
REQ-011 The module SHALL have ports rw0_..rw3_, input, 1 bit each: `Read/`Write per master.
REQ-012 The module SHALL have ports maddr, mwdata and mrw_, outputs: the muxed address, data and rw of the owner, toward memory/IO.
REQ-013 The module SHALL have ports mem_cs_ and io_cs_, outputs, 1 bit each, active low: the address-decoded selects.
REQ-014 The module SHALL have port tout, output, 1 bit: a one-cycle pulse on forced release.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT and TURN.
- IDLE: any breq_ low at an edge -> GRANT, winner's bgrt_ low after that edge (1-cycle latency).
- GRANT: held while owner's breq_ low.
- Owner breq_ high at an edge -> TURN, all bgrt_ high.
- TURN: lasts exactly one cycle, then -> GRANT (new winner) if any request is pending, else -> IDLE.
REQ-016 Winner selection SHALL be round-robin: the first low breq_ scanning upward (mod 4) from pointer rr.
- rr SHALL load owner+1 (mod 4) on every grant.
- rr SHALL reset to 0.
REQ-017 In GRANT, maddr/mwdata/mrw_ SHALL combinationally follow the owner's inputs.
- Outside GRANT: maddr=0, mwdata=0, mrw_=`Read.
REQ-018 In GRANT, mem_cs_ SHALL be low iff maddr < IO_BASE; io_cs_ SHALL be low iff maddr >= IO_BASE.
- Both selects SHALL be high outside GRANT.
REQ-019 An 8-bit tenure counter SHALL clear on entry to GRANT and increment each GRANT cycle, saturating at 255.
REQ-020 Forced release: when MAX_TENURE != 0, count == MAX_TENURE-1 and another master requests at an edge:
- the FSM SHALL go to TURN;
- tout SHALL pulse for one cycle;
- rr SHALL skip the preempted master.
REQ-021 With no competing request, the owner SHALL keep the grant indefinitely regardless of tenure.
REQ-022 Owner release and new requests at the same edge SHALL still pass through TURN; no back-to-back grants.
REQ-023 A master SHALL never see bgrt_ low in the cycle directly after any other master's bgrt_ was low.

Reset
REQ-024 reset_ low SHALL immediately force:
- bgrt_=4'hF, mem_cs_=1, io_cs_=1, tout=0, mrw_=`Read, maddr=0, mwdata=0;
- state=IDLE, rr=0, tenure=0.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant asynchronously; arbitration SHALL restart from IDLE on the first edge after release.

Structure
REQ-026 `Enable_, `Disable_, `Read, `Write, BUS_ADDR_WIDTH, DATA_WIDTH, IO_BASE and the FSM state encodings SHALL live in the shared define.h.
REQ-027 The round-robin selection SHALL be the combinational sub-module rr_pick: inputs 4-bit request and 2-bit pointer; outputs 2-bit winner and valid.

Verification
REQ-028 Scenario 1: release reset; breq_=4'b1110 -> bgrt_=4'b1110 one edge later; rw0_=`Write, addr0=10'h150, wdata0=8'h99 -> maddr=10'h150, mem_cs_=0, io_cs_=1.
REQ-029 Scenario 2: breq_=4'b1010 held -> grants in order CPU0, CPU2(DMA), CPU0 with a 1-cycle all-high TURN gap between each.
REQ-030 Scenario 3: DMA owner, addr2=10'h204 -> io_cs_=0, mem_cs_=1; addr2=10'h1FF -> mem_cs_=0.
REQ-031 Scenario 4: MAX_TENURE=4; CPU0 holds breq_ while CPU1 requests from cycle 1 -> bgrt_[0] high after 4 grant cycles, tout pulses once, CPU1 granted after TURN.
REQ-032 Scenario 5: reset_ low during a DMA grant -> bgrt_=4'hF and both selects high before the next clock edge; first grant after reset goes to the lowest requester from rr=0.
